// File: rtl/alu_uart_interface.sv
// rtl/alu_uart_interface.sv - UART byte-stream front end for the combinational ALU
// Optional inter-byte frame timeout enabled by defining FRAME_TIMEOUT_EN.
module alu_uart_interface #(
  parameter int N_BITS         = 8,
  parameter int OP_BITS        = 6,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [N_BITS-1:0]  rx_data,
  input  logic               tx_ready,
  output logic               tx_start,
  output logic [N_BITS-1:0]  tx_data,
  output logic [N_BITS-1:0]  alu_d0,
  output logic [N_BITS-1:0]  alu_d1,
  output logic [OP_BITS-1:0] alu_opcode,
  input  logic [N_BITS-1:0]  alu_result,
  output logic               overrun
);

  typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_OP, SEND} state_t;

  state_t              state, state_nxt;
  logic [N_BITS-1:0]   d0_nxt, d1_nxt, tx_data_nxt;
  logic [OP_BITS-1:0]  op_nxt;
  logic                tx_start_nxt, overrun_nxt;
  logic                timeout;

`ifdef FRAME_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             mid_frame;

  assign mid_frame = (state == WAIT_B) || (state == WAIT_OP);
  assign timeout   = mid_frame && !rx_valid && (idle_cnt == CNT_MAX);

  // Counts only idle cycles inside a frame; any accepted byte or return to WAIT_A clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (mid_frame && !rx_valid && !timeout) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_A;
      alu_d0     <= '0;
      alu_d1     <= '0;
      alu_opcode <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      alu_d0     <= d0_nxt;
      alu_d1     <= d1_nxt;
      alu_opcode <= op_nxt;
      tx_data    <= tx_data_nxt;
      tx_start   <= tx_start_nxt;
      overrun    <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_A:  if (rx_valid) state_nxt = WAIT_B;
      WAIT_B:  if (rx_valid) state_nxt = WAIT_OP;
               else if (timeout) state_nxt = WAIT_A;
      WAIT_OP: if (rx_valid) state_nxt = SEND;
               else if (timeout) state_nxt = WAIT_A;
      SEND:    if (tx_ready) state_nxt = WAIT_A;
      default: state_nxt = WAIT_A;
    endcase
  end

  always_comb begin
    d0_nxt       = alu_d0;
    d1_nxt       = alu_d1;
    op_nxt       = alu_opcode;
    tx_data_nxt  = tx_data;
    tx_start_nxt = 1'b0;
    overrun_nxt  = overrun;
    case (state)
      WAIT_A:  if (rx_valid) d0_nxt = rx_data;
      WAIT_B:  if (rx_valid) d1_nxt = rx_data;
      WAIT_OP: if (rx_valid) op_nxt = rx_data[OP_BITS-1:0];
      SEND: begin
        if (tx_ready) begin
          tx_data_nxt  = alu_result;
          tx_start_nxt = 1'b1;
        end
        // A byte arriving while the result is still pending cannot be buffered.
        if (rx_valid) overrun_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
// tb/tb_alu_uart_interface.sv - self-checking bench for alu_uart_interface
module tb_alu_uart_interface;

  localparam int N  = 8;
  localparam int OP = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [N-1:0]  rx_data = '0;
  logic          tx_ready = 1'b0;
  logic          tx_start;
  logic [N-1:0]  tx_data;
  logic [N-1:0]  alu_d0, alu_d1;
  logic [OP-1:0] alu_opcode;
  logic [N-1:0]  alu_result;
  logic          overrun;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int exp_pulses = 0;

  always #5 clk = ~clk;

  alu_uart_interface #(
    .N_BITS(N), .OP_BITS(OP), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .alu_d0(alu_d0), .alu_d1(alu_d1), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .overrun(overrun)
  );

  function automatic logic [N-1:0] alu_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [OP-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_d0, alu_d1, alu_opcode);

  always @(negedge clk) if (rst_n && tx_start) pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [N-1:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] op,
                           input logic [N-1:0] exp, input int stall);
    tx_ready = 1'b0;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check("send_entry_no_start", tx_start, 0);
    check("alu_d0", alu_d0, a);
    check("alu_d1", alu_d1, b);
    check("alu_opcode", alu_opcode, op & 8'h3F);
    repeat (stall) @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    check("tx_start_pulse", tx_start, 1);
    check("tx_data", tx_data, exp);
    exp_pulses++;
    @(negedge clk);
    check("tx_start_single", tx_start, 0);
  endtask

  typedef struct {
    logic [N-1:0] a, b, op, exp;
  } vec_t;

  vec_t vecs[6];
  logic [N-1:0] ops[6];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
    vecs[1] = '{8'h05, 8'h07, 8'h22, 8'hFE};
    vecs[2] = '{8'hF0, 8'h3C, 8'h27, 8'h03};
    vecs[3] = '{8'h01, 8'h02, 8'hFF, 8'h00};
    vecs[4] = '{8'hF0, 8'h3C, 8'h24, 8'h30};
    vecs[5] = '{8'hF0, 8'h3C, 8'h26, 8'hCC};
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27};

    repeat (2) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_d0", alu_d0, 0);
    check("rst_d1", alu_d1, 0);
    check("rst_opcode", alu_opcode, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 0);

    // Transmitter busy for 10 cycles with a stray byte arriving meanwhile.
    tx_ready = 1'b0;
    send_byte(8'h09);
    send_byte(8'h04);
    send_byte(8'h20);
    repeat (4) @(negedge clk);
    send_byte(8'h77);
    repeat (4) @(negedge clk);
    check("stall_no_start", pulses, exp_pulses);
    check("overrun_set", overrun, 1);
    tx_ready = 1'b1;
    @(negedge clk);
    check("stall_tx_start", tx_start, 1);
    check("stall_tx_data", tx_data, 8'h0D);
    check("stall_d1_kept", alu_d1, 8'h04);
    exp_pulses++;
    run_frame(8'h02, 8'h03, 8'h25, 8'h03, 2);
    check("overrun_sticky", overrun, 1);

    // Reset in the middle of a frame.
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    check("mid_rst_d0", alu_d0, 0);
    check("mid_rst_d1", alu_d1, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_tx_data", tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_start", pulses, exp_pulses);
    run_frame(8'h01, 8'h01, 8'h20, 8'h02, 0);

`ifdef FRAME_TIMEOUT_EN
    send_byte(8'hAA);
    repeat (20) @(negedge clk);
    run_frame(8'h01, 8'h02, 8'h20, 8'h03, 0);
    check("timeout_no_stale_start", pulses, exp_pulses);
`endif

    for (int n = 0; n < 150; n++) begin
      logic [N-1:0] a, b, op;
      a  = N'($urandom);
      b  = N'($urandom);
      op = ($urandom_range(0, 3) == 0) ? N'($urandom) : ops[$urandom_range(0, 5)];
      run_frame(a, b, op, alu_ref(a, b, op[OP-1:0]), $urandom_range(0, 3));
    end

    check("total_tx_pulses", pulses, exp_pulses);
    check("no_spurious_overrun", overrun, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
